// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter and sequencer for one shared memory port serving three
//   requesters (0 = instruction fetch, 1 = load/store, 2 = debug). One
//   transaction is in flight at a time; the winner's addr/wdata are steered onto
//   the port through a 3:1 mux selected by sel_o (00=a, 01=b, 10=c).
//
//   Ports:
//     clk, rst       clock (rising edge), asynchronous active-high reset
//     req_i[2:0]     per-requester request, held until its done_o bit pulses
//     we_i[2:0]      per-requester write enable, sampled with req_i
//     addr_i         {addr2,addr1,addr0}, AW bits each
//     wdata_i        {wdata2,wdata1,wdata0}, DW bits each
//     sel_o          mux select of the current owner (never 11)
//     mem_req_o      port request, high for the whole BUSY phase
//     mem_we_o       port write enable
//     mem_addr_o     address of the selected requester
//     mem_wdata_o    write data of the selected requester
//     mem_ready_i    port completes the transaction this cycle
//     mem_rdata_i    port read data, valid with mem_ready_i
//     done_o         one-hot, single-cycle completion pulse to the owner
//     rdata_o        registered read data (0 for writes), valid with done_o
//     err_o          timeout abort flag, valid with done_o
//
//   Optional feature: define ARB_TIMEOUT_EN to abort a BUSY phase after TIMEOUT
//   cycles without mem_ready_i. Without it err_o is tied low and BUSY waits
//   indefinitely.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      req_i,
  input  logic [2:0]      we_i,
  input  logic [3*AW-1:0] addr_i,
  input  logic [3*DW-1:0] wdata_i,
  output logic [1:0]      sel_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic            mem_ready_i,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic [2:0]      done_o,
  output logic [DW-1:0]   rdata_o,
  output logic            err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_n;
  logic [1:0]    last, last_n;
  logic [1:0]    sel_n;
  logic          we_n;
  logic [2:0]    done_n;
  logic [DW-1:0] rdata_n;
  logic [1:0]    winner;
  logic [1:0]    cand;
  logic          found;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic          err_q, err_n;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Scan last+1, last+2, last (mod 3); the previous owner has lowest priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 1; k <= 3; k++) begin
      cand = 2'((32'(last) + k) % 3);
      if (!found && req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel_o;
    last_n  = last;
    we_n    = mem_we_o;
    done_n  = '0;
    rdata_n = rdata_o;
`ifdef ARB_TIMEOUT_EN
    cnt_n   = cnt;
    err_n   = err_q;
`endif
    case (state)
      IDLE: begin
        if (|req_i) begin
          sel_n   = winner;
          last_n  = winner;
          we_n    = we_i[winner];
          state_n = BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      BUSY: begin
        if (mem_ready_i) begin
          rdata_n = mem_we_o ? '0 : mem_rdata_i;
          done_n  = 3'b001 << sel_o;
          state_n = DONE;
`ifdef ARB_TIMEOUT_EN
          err_n   = 1'b0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th BUSY cycle without ready: abort.
          rdata_n = '0;
          done_n  = 3'b001 << sel_o;
          err_n   = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n   = cnt + 1'b1;
`endif
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel_o    <= '0;
      last     <= 2'b10;
      mem_we_o <= 1'b0;
      done_o   <= '0;
      rdata_o  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt      <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      sel_o    <= sel_n;
      last     <= last_n;
      mem_we_o <= we_n;
      done_o   <= done_n;
      rdata_o  <= rdata_n;
`ifdef ARB_TIMEOUT_EN
      cnt      <= cnt_n;
      err_q    <= err_n;
`endif
    end
  end

  assign mem_req_o = (state == BUSY);

  always_comb begin
    case (sel_o)
      2'b01: begin
        mem_addr_o  = addr_i[AW +: AW];
        mem_wdata_o = wdata_i[DW +: DW];
      end
      2'b10: begin
        mem_addr_o  = addr_i[2*AW +: AW];
        mem_wdata_o = wdata_i[2*DW +: DW];
      end
      default: begin
        mem_addr_o  = addr_i[0 +: AW];
        mem_wdata_o = wdata_i[0 +: DW];
      end
    endcase
  end

endmodule
